// File: rtl/rdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rdm_pkg
// Description : Shared types and default sizing for the circular-buffer
//               rate dematcher (FSM state encoding, default widths).
// Revision    : 1.0 - initial release
// ============================================================================
package rdm_pkg;

    // Default sizing of the dematcher datapath
    localparam int c_DEF_LANES  = 16;   // LLRs per input-buffer word
    localparam int c_DEF_LLR_W  = 6;    // bits per LLR
    localparam int c_DEF_E_W    = 14;   // rate-matched length counter width
    localparam int c_DEF_NCB_W  = 16;   // Ncb / k0 / filler field width
    localparam int c_DEF_ADDR_W = 16;   // input-buffer address width

    // Job sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_FETCH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_EMIT  = 3'd4,
        ST_DONE  = 3'd5
    } rdm_state_e;

endpackage : rdm_pkg
`default_nettype wire

// File: rtl/rdm_pos_advance.sv
`default_nettype none
// ============================================================================
// Module      : rdm_pos_advance
// Description : Combinational circular-buffer position step.
//               next = pos + step, wrapping Ncb -> 0, then jumping over the
//               filler region [filler_start, filler_start+filler_len) with a
//               second wrap if the filler runs to the end of the buffer.
//               With i_step=0 it normalises a start offset (k0) that may lie
//               inside the filler.
// Ports       : i_pos          current position (< Ncb)
//               i_step         1: advance by one, 0: normalise i_pos only
//               i_ncb          circular buffer length
//               i_filler_start first filler position
//               i_filler_len   filler length (0 = no filler)
//               o_next         resulting position
//               o_wrapped      position passed Ncb-1 back to 0
// Revision    : 1.0 - initial release
// ============================================================================
module rdm_pos_advance #(
    parameter int NCB_W = 16
) (
    input  logic [NCB_W-1:0] i_pos,
    input  logic             i_step,
    input  logic [NCB_W-1:0] i_ncb,
    input  logic [NCB_W-1:0] i_filler_start,
    input  logic [NCB_W-1:0] i_filler_len,
    output logic [NCB_W-1:0] o_next,
    output logic             o_wrapped
);

    // One extra bit so pos+1 and filler_start+filler_len never overflow
    logic [NCB_W:0]   w_cand;
    logic             w_wrap_inc;
    logic [NCB_W:0]   w_after_inc;
    logic [NCB_W:0]   w_fill_end;
    logic             w_in_fill;
    logic             w_wrap_fill;

    assign w_cand      = {1'b0, i_pos} + {{NCB_W{1'b0}}, i_step};
    assign w_wrap_inc  = (w_cand >= {1'b0, i_ncb});
    assign w_after_inc = w_wrap_inc ? '0 : w_cand;

    // An empty filler (len 0) yields fill_end == filler_start, so the range
    // test below can never hit.
    assign w_fill_end  = {1'b0, i_filler_start} + {1'b0, i_filler_len};
    assign w_in_fill   = (w_after_inc >= {1'b0, i_filler_start}) &&
                         (w_after_inc <  w_fill_end);
    assign w_wrap_fill = w_in_fill && (w_fill_end >= {1'b0, i_ncb});

    assign o_next    = !w_in_fill  ? w_after_inc[NCB_W-1:0] :
                       w_wrap_fill ? '0 : w_fill_end[NCB_W-1:0];
    assign o_wrapped = w_wrap_inc | w_wrap_fill;

endmodule : rdm_pos_advance
`default_nettype wire

// File: rtl/rdm_circ_dematcher.sv
`default_nettype none
// ============================================================================
// Module      : rdm_circ_dematcher
// Description : Rate-dematching sequencer for the HARQ combine path.
//               Reads packed LLR words from the RDM input buffer, serialises
//               the first E LLRs and tags each with its circular-buffer
//               position (start k0, wrap at Ncb, filler skipped) and a
//               first-pass flag, under a valid/ready handshake.
// Ports       : i_core_clk / i_rx_rstn         clock, async active-low reset
//               i_start + i_e_size .. i_base_addr   job request and config
//               o_Input_Buffer_Offset_Address, o_rd_en,
//               i_Input_Buffer_RDM_Data        input buffer read port
//                                              (data 1 cycle after o_rd_en,
//                                              lane 0 in the MSBs)
//               o_llr, o_ncb_addr, o_first_pass, o_valid, i_ready
//                                              soft-combine beat stream
//               o_busy, o_done, o_cfg_err      job status
// Revision    : 1.0 - initial release
// ============================================================================
module rdm_circ_dematcher
    import rdm_pkg::*;
#(
    parameter int LANES  = c_DEF_LANES,
    parameter int LLR_W  = c_DEF_LLR_W,
    parameter int E_W    = c_DEF_E_W,
    parameter int NCB_W  = c_DEF_NCB_W,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rstn,
    input  logic                     i_start,
    input  logic [E_W-1:0]           i_e_size,
    input  logic [NCB_W-1:0]         i_ncb_size,
    input  logic [NCB_W-1:0]         i_k0,
    input  logic [NCB_W-1:0]         i_filler_start,
    input  logic [NCB_W-1:0]         i_filler_len,
    input  logic [ADDR_W-1:0]        i_base_addr,
    output logic [ADDR_W-1:0]        o_Input_Buffer_Offset_Address,
    output logic                     o_rd_en,
    input  logic [LANES*LLR_W-1:0]   i_Input_Buffer_RDM_Data,
    output logic [LLR_W-1:0]         o_llr,
    output logic [NCB_W-1:0]         o_ncb_addr,
    output logic                     o_first_pass,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_cfg_err
);

    localparam int c_LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_WORD_W = LANES * LLR_W;

    // ------------------------------------------------------------------
    // State and registered job context
    // ------------------------------------------------------------------
    rdm_state_e          r_state;
    rdm_state_e          w_state_nxt;

    logic [NCB_W-1:0]    r_ncb;
    logic [NCB_W-1:0]    r_k0;
    logic [NCB_W-1:0]    r_fill_start;
    logic [NCB_W-1:0]    r_fill_len;
    logic [ADDR_W-1:0]   r_base;

    logic [NCB_W-1:0]    r_pos;
    logic                r_first_pass;
    logic [E_W-1:0]      r_remain;
    logic [c_LANE_W-1:0] r_lane;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [c_WORD_W-1:0] r_word;
    logic                r_cfg_err;

    // ------------------------------------------------------------------
    // Position stepping: one shared instance. In CHECK it normalises k0
    // (no increment); in EMIT it advances the current position.
    // ------------------------------------------------------------------
    logic                w_adv_is_start;
    logic [NCB_W-1:0]    w_adv_pos;
    logic [NCB_W-1:0]    w_adv_next;
    logic                w_adv_wrapped;

    assign w_adv_is_start = (r_state == ST_CHECK);
    assign w_adv_pos      = w_adv_is_start ? r_k0 : r_pos;

    rdm_pos_advance #(
        .NCB_W          (NCB_W)
    ) u_pos_adv (
        .i_pos          (w_adv_pos),
        .i_step         (!w_adv_is_start),
        .i_ncb          (r_ncb),
        .i_filler_start (r_fill_start),
        .i_filler_len   (r_fill_len),
        .o_next         (w_adv_next),
        .o_wrapped      (w_adv_wrapped)
    );

    // ------------------------------------------------------------------
    // Configuration sanity, evaluated on the registered job context
    // ------------------------------------------------------------------
    logic [NCB_W:0]      w_fill_end_ext;
    logic                w_cfg_bad;

    assign w_fill_end_ext = {1'b0, r_fill_start} + {1'b0, r_fill_len};
    assign w_cfg_bad      = (r_ncb == '0)                     ||
                            (r_k0 >= r_ncb)                   ||
                            (w_fill_end_ext > {1'b0, r_ncb})  ||
                            (r_fill_len >= r_ncb);

    // ------------------------------------------------------------------
    // Beat bookkeeping
    // ------------------------------------------------------------------
    logic                w_beat;
    logic                w_last_beat;
    logic                w_last_lane;

    assign w_beat      = (r_state == ST_EMIT) && i_ready;
    assign w_last_beat = (r_remain == E_W'(1));
    assign w_last_lane = (r_lane == c_LANE_W'(LANES - 1));

    // Split the captured word into lanes; lane 0 sits in the MSBs.
    logic [LLR_W-1:0]    w_lane_llr [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_split
        assign w_lane_llr[gi] = r_word[(LANES-1-gi)*LLR_W +: LLR_W];
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_rd_en     = 1'b0;
        o_valid     = 1'b0;
        o_done      = 1'b0;
        o_busy      = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_cfg_bad || (r_remain == '0)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_rd_en     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    // Finishing E takes priority over a word boundary so a
                    // partial last word never triggers an extra read.
                    if (w_last_beat) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_last_lane) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            r_ncb        <= '0;
            r_k0         <= '0;
            r_fill_start <= '0;
            r_fill_len   <= '0;
            r_base       <= '0;
            r_pos        <= '0;
            r_first_pass <= 1'b0;
            r_remain     <= '0;
            r_lane       <= '0;
            r_word_idx   <= '0;
            r_word       <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_ncb        <= i_ncb_size;
                        r_k0         <= i_k0;
                        r_fill_start <= i_filler_start;
                        r_fill_len   <= i_filler_len;
                        r_base       <= i_base_addr;
                        r_remain     <= i_e_size;
                        r_lane       <= '0;
                        r_word_idx   <= '0;
                        r_first_pass <= 1'b1;
                        r_cfg_err    <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_pos <= w_adv_next;
                    if (w_cfg_bad) begin
                        r_cfg_err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    r_word <= i_Input_Buffer_RDM_Data;
                end
                ST_EMIT: begin
                    if (w_beat) begin
                        r_remain <= r_remain - E_W'(1);
                        r_pos    <= w_adv_next;
                        // Once wrapped, every later beat is a combine (add)
                        if (w_adv_wrapped) begin
                            r_first_pass <= 1'b0;
                        end
                        if (w_last_lane) begin
                            r_lane     <= '0;
                            r_word_idx <= r_word_idx + ADDR_W'(1);
                        end else begin
                            r_lane <= r_lane + c_LANE_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat and address outputs; beat fields are forced to 0 outside EMIT
    // ------------------------------------------------------------------
    assign o_Input_Buffer_Offset_Address = r_base + r_word_idx;
    assign o_llr        = (r_state == ST_EMIT) ? w_lane_llr[r_lane] : '0;
    assign o_ncb_addr   = (r_state == ST_EMIT) ? r_pos : '0;
    assign o_first_pass = (r_state == ST_EMIT) && r_first_pass;
    assign o_cfg_err    = r_cfg_err;

endmodule : rdm_circ_dematcher
`default_nettype wire

// File: tb/tb_rdm_circ_dematcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_rdm_circ_dematcher
// Description : Directed self-checking bench for rdm_circ_dematcher.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rdm_circ_dematcher;

    localparam int LANES  = 16;
    localparam int LLR_W  = 6;
    localparam int E_W    = 14;
    localparam int NCB_W  = 16;
    localparam int ADDR_W = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   i_start;
    logic [E_W-1:0]         i_e_size;
    logic [NCB_W-1:0]       i_ncb_size;
    logic [NCB_W-1:0]       i_k0;
    logic [NCB_W-1:0]       i_filler_start;
    logic [NCB_W-1:0]       i_filler_len;
    logic [ADDR_W-1:0]      i_base_addr;
    logic [ADDR_W-1:0]      o_addr;
    logic                   o_rd_en;
    logic [LANES*LLR_W-1:0] rdata;
    logic [LLR_W-1:0]       o_llr;
    logic [NCB_W-1:0]       o_ncb_addr;
    logic                   o_first_pass;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_cfg_err;

    always #5 clk = ~clk;

    rdm_circ_dematcher #(
        .LANES (LANES), .LLR_W (LLR_W), .E_W (E_W), .NCB_W (NCB_W), .ADDR_W (ADDR_W)
    ) dut (
        .i_core_clk                    (clk),
        .i_rx_rstn                     (rst_n),
        .i_start                       (i_start),
        .i_e_size                      (i_e_size),
        .i_ncb_size                    (i_ncb_size),
        .i_k0                          (i_k0),
        .i_filler_start                (i_filler_start),
        .i_filler_len                  (i_filler_len),
        .i_base_addr                   (i_base_addr),
        .o_Input_Buffer_Offset_Address (o_addr),
        .o_rd_en                       (o_rd_en),
        .i_Input_Buffer_RDM_Data       (rdata),
        .o_llr                         (o_llr),
        .o_ncb_addr                    (o_ncb_addr),
        .o_first_pass                  (o_first_pass),
        .o_valid                       (o_valid),
        .i_ready                       (i_ready),
        .o_busy                        (o_busy),
        .o_done                        (o_done),
        .o_cfg_err                     (o_cfg_err)
    );

    // Input buffer content: the LLR stored at word a, lane l
    function automatic logic [LLR_W-1:0] llr_of(input int a, input int l);
        int v;
        v = (a * 5 + l * 3 + 1) % 64;
        return LLR_W'(v);
    endfunction

    function automatic logic [LANES*LLR_W-1:0] mk_word(input int a);
        logic [LANES*LLR_W-1:0] w;
        w = '0;
        for (int l = 0; l < LANES; l++) w[(LANES-1-l)*LLR_W +: LLR_W] = llr_of(a, l);
        return w;
    endfunction

    // Read port: data appears one cycle after the strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rdata <= '0;
        else if (o_rd_en) rdata <= mk_word(int'(o_addr));
    end

    int checks   = 0;
    int failures = 0;

    int exp_addr[$];
    bit exp_fp[$];
    int obs_addr[$];
    bit obs_fp[$];
    logic [LLR_W-1:0] obs_llr[$];
    int beats, reads, dones, first_valid_k, done_k, last_rd_addr;
    bit aborted;

    // Reference: list the non-filler positions in order, find where k0 lands,
    // then walk that list circularly. First pass lasts until the list end.
    task automatic build_expected(input int e, input int ncb, input int k0,
                                  input int fs, input int fl);
        int list[$];
        int s;
        s = -1;
        exp_addr.delete();
        exp_fp.delete();
        for (int p = 0; p < ncb; p++) if (!(p >= fs && p < fs + fl)) list.push_back(p);
        for (int i = 0; i < list.size(); i++) if (s < 0 && list[i] >= k0) s = i;
        if (s < 0) s = 0;
        if (list.size() == 0) return;
        for (int n = 0; n < e; n++) begin
            exp_addr.push_back(list[(s + n) % list.size()]);
            exp_fp.push_back((s + n) < list.size());
        end
    endtask

    // rmode 0: always ready, 1: random ready. inject: stray start mid-job.
    // rst_at >= 0: assert reset while beat rst_at is presented.
    task automatic run_job(input int e, input int ncb, input int k0, input int fs,
                           input int fl, input int base, input int rmode,
                           input int inject, input int rst_at);
        int n, k;
        bit prev_stall;
        logic [LLR_W+NCB_W:0] cur_vec, prev_vec, exp_vec;
        build_expected(e, ncb, k0, fs, fl);
        obs_addr.delete(); obs_fp.delete(); obs_llr.delete();
        n = 0; k = 0; reads = 0; dones = 0; first_valid_k = -1; done_k = -1;
        last_rd_addr = -1; aborted = 0; prev_stall = 0; prev_vec = '0;
        @(negedge clk);
        i_e_size       = E_W'(e);
        i_ncb_size     = NCB_W'(ncb);
        i_k0           = NCB_W'(k0);
        i_filler_start = NCB_W'(fs);
        i_filler_len   = NCB_W'(fl);
        i_base_addr    = ADDR_W'(base);
        i_start        = 1'b1;
        i_ready        = 1'b1;
        while (dones == 0 && k < 3000 && !aborted) begin
            @(negedge clk);
            k++;
            i_start = (inject != 0 && k == 20);
            if (inject != 0 && k == 20) begin
                i_e_size = E_W'(5);
                i_k0     = NCB_W'(1);
            end
            i_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == 1) begin
                checks++;
                if (o_busy !== 1'b1 || o_cfg_err !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_after_start: busy=%b cfg_err=%b required busy=1 cfg_err=0", o_busy, o_cfg_err);
                end
            end
            if (o_rd_en) begin
                checks++;
                if (int'(o_addr) !== base + reads) begin
                    failures++;
                    $display("FAIL read_addr: got %0h required %0h", o_addr, base + reads);
                end
                last_rd_addr = int'(o_addr);
                reads++;
            end
            if (o_valid) begin
                if (first_valid_k < 0) first_valid_k = k;
                cur_vec = {o_llr, o_ncb_addr, o_first_pass};
                if (prev_stall) begin
                    checks++;
                    if (cur_vec !== prev_vec) begin
                        failures++;
                        $display("FAIL stall_hold: got %0h held %0h", cur_vec, prev_vec);
                    end
                end
                checks++;
                if (n >= e) begin
                    failures++;
                    $display("FAIL extra_beat: beat %0d got, only %0d required", n, e);
                end else begin
                    exp_vec = {llr_of(base + n / LANES, n % LANES), NCB_W'(exp_addr[n]), exp_fp[n]};
                    if (cur_vec !== exp_vec) begin
                        failures++;
                        $display("FAIL beat_%0d: got llr=%0d addr=%0d fp=%b required llr=%0d addr=%0d fp=%b",
                                 n, o_llr, o_ncb_addr, o_first_pass,
                                 exp_vec[LLR_W+NCB_W:NCB_W+1], exp_vec[NCB_W:1], exp_vec[0]);
                    end
                end
                if (rst_at >= 0 && n == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    checks++;
                    if ({o_addr, o_rd_en, o_llr, o_ncb_addr, o_first_pass, o_valid,
                         o_busy, o_done, o_cfg_err} !== '0) begin
                        failures++;
                        $display("FAIL outputs_in_mid_reset: valid=%b busy=%b llr=%0d addr=%0d rdaddr=%0h required all 0",
                                 o_valid, o_busy, o_llr, o_ncb_addr, o_addr);
                    end
                    aborted = 1;
                end else begin
                    if (i_ready && n < e) begin
                        obs_addr.push_back(int'(o_ncb_addr));
                        obs_fp.push_back(o_first_pass);
                        obs_llr.push_back(o_llr);
                    end
                    if (i_ready) n++;
                end
                prev_stall = !i_ready;
                prev_vec   = cur_vec;
            end else begin
                prev_stall = 0;
            end
            if (o_done) begin
                dones++;
                done_k = k;
            end
        end
        if (!aborted && dones == 0) begin
            checks++;
            failures++;
            $display("FAIL job_timeout: no done after %0d cycles, beats=%0d", k, n);
        end
        beats   = n;
        i_start = 1'b0;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_addr, o_rd_en, o_llr, o_ncb_addr, o_first_pass, o_valid,
             o_busy, o_done, o_cfg_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b valid=%b rd=%b done=%b err=%b required all 0",
                     o_busy, o_valid, o_rd_en, o_done, o_cfg_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", o_busy, o_valid);
        end
    endtask

    // Common end-of-job checks for the 138-beat Ncb=98 job at base 0x100
    task automatic check_long_job(input string tag, input int exp_done_k);
        checks++;
        if (beats !== 138 || reads !== 9 || dones !== 1 || last_rd_addr !== 'h108) begin
            failures++;
            $display("FAIL %s_counts: beats=%0d reads=%0d dones=%0d last_rd=%0h required 138 9 1 108",
                     tag, beats, reads, dones, last_rd_addr);
        end
        checks++;
        if (first_valid_k !== 4) begin
            failures++;
            $display("FAIL %s_first_valid: cycle %0d required 4", tag, first_valid_k);
        end
        if (exp_done_k > 0) begin
            checks++;
            if (done_k !== exp_done_k) begin
                failures++;
                $display("FAIL %s_done_cycle: cycle %0d required %0d", tag, done_k, exp_done_k);
            end
        end
        if (obs_addr.size() == 138) begin
            checks++;
            if (obs_addr[97] !== 97 || obs_addr[98] !== 0 || obs_addr[137] !== 39 ||
                obs_fp[97] !== 1'b1 || obs_fp[98] !== 1'b0 || obs_llr[137] !== 6'd4) begin
                failures++;
                $display("FAIL %s_wrap_points: a97=%0d a98=%0d a137=%0d fp97=%b fp98=%b llr137=%0d required 97 0 39 1 0 4",
                         tag, obs_addr[97], obs_addr[98], obs_addr[137], obs_fp[97], obs_fp[98], obs_llr[137]);
            end
        end
        checks++;
        if (o_cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_cfg_err: got %b required 0", tag, o_cfg_err);
        end
    endtask

    task automatic test_basic();
        run_job(138, 98, 0, 0, 0, 'h100, 0, 0, -1);
        // 9 words of 18 cycles each, last word ends on lane 9 -> DONE at 158
        check_long_job("basic", 158);
    endtask

    task automatic test_filler();
        int hand[10] = '{5, 6, 7, 12, 13, 14, 15, 16, 17, 18};
        run_job(10, 20, 5, 8, 4, 'h40, 0, 0, -1);
        checks++;
        if (beats !== 10 || reads !== 1 || dones !== 1) begin
            failures++;
            $display("FAIL filler_counts: beats=%0d reads=%0d dones=%0d required 10 1 1", beats, reads, dones);
        end
        for (int i = 0; i < 10 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== hand[i] || obs_fp[i] !== 1'b1) begin
                failures++;
                $display("FAIL filler_seq_%0d: addr=%0d fp=%b required addr=%0d fp=1", i, obs_addr[i], obs_fp[i], hand[i]);
            end
        end
    endtask

    task automatic test_k0_in_filler();
        int hand[12] = '{12, 13, 14, 15, 16, 17, 18, 19, 0, 1, 2, 3};
        run_job(12, 20, 9, 8, 4, 'h0, 0, 0, -1);
        checks++;
        if (beats !== 12 || obs_addr.size() !== 12) begin
            failures++;
            $display("FAIL k0fill_count: beats=%0d recorded=%0d required 12", beats, obs_addr.size());
        end
        for (int i = 0; i < 12 && i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] !== hand[i] || obs_fp[i] !== (i < 8)) begin
                failures++;
                $display("FAIL k0fill_seq_%0d: addr=%0d fp=%b required addr=%0d fp=%b",
                         i, obs_addr[i], obs_fp[i], hand[i], (i < 8));
            end
        end
    endtask

    task automatic test_backpressure();
        // Random ready plus a stray start at cycle 20 that must be ignored
        run_job(138, 98, 0, 0, 0, 'h100, 1, 1, -1);
        check_long_job("backpressure", 0);
    endtask

    task automatic test_e_zero();
        run_job(0, 98, 0, 0, 0, 'h100, 0, 0, -1);
        checks++;
        if (done_k !== 2 || reads !== 0 || beats !== 0 || dones !== 1 || o_cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL e_zero: done_cycle=%0d reads=%0d beats=%0d dones=%0d err=%b required 2 0 0 1 0",
                     done_k, reads, beats, dones, o_cfg_err);
        end
    endtask

    task automatic test_cfg_err();
        run_job(5, 98, 98, 0, 0, 'h100, 0, 0, -1);
        checks++;
        if (o_cfg_err !== 1'b1 || reads !== 0 || beats !== 0 || dones !== 1 || done_k !== 2) begin
            failures++;
            $display("FAIL cfg_err_k0: err=%b reads=%0d beats=%0d dones=%0d done_cycle=%0d required 1 0 0 1 2",
                     o_cfg_err, reads, beats, dones, done_k);
        end
        // Filler running past Ncb
        run_job(5, 20, 0, 18, 4, 'h100, 0, 0, -1);
        checks++;
        if (o_cfg_err !== 1'b1 || reads !== 0 || beats !== 0 || dones !== 1) begin
            failures++;
            $display("FAIL cfg_err_filler: err=%b reads=%0d beats=%0d dones=%0d required 1 0 0 1",
                     o_cfg_err, reads, beats, dones);
        end
    endtask

    task automatic test_reset_mid();
        run_job(138, 98, 0, 0, 0, 'h100, 0, 0, 50);
        checks++;
        if (aborted !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_reached: aborted=%b required 1", aborted);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_done !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_hold: done=%b valid=%b busy=%b required 0 0 0", o_done, o_valid, o_busy);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_job(138, 98, 0, 0, 0, 'h100, 0, 0, -1);
        check_long_job("after_reset", 158);
    endtask

    initial begin
        rst_n          = 1'b0;
        i_start        = 1'b0;
        i_e_size       = '0;
        i_ncb_size     = '0;
        i_k0           = '0;
        i_filler_start = '0;
        i_filler_len   = '0;
        i_base_addr    = '0;
        i_ready        = 1'b0;
        test_reset();
        test_basic();
        test_filler();
        test_k0_in_filler();
        test_backpressure();
        test_e_zero();
        test_cfg_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rdm_circ_dematcher
`default_nettype wire

// File: doc/rdm_circ_dematcher.md
Name: rdm_circ_dematcher

Overview:
- Parametrised rate-dematching FSM for the HARQ combine path.
- Fetches packed LLR words from the RDM input buffer and serialises the first E LLRs.
- Maps each LLR onto the circular buffer of size Ncb, starting at offset k0 and skipping a contiguous filler region.
- Emits a stream of (LLR, Ncb address, first-pass flag) under a valid/ready handshake to the downstream soft-combine stage.
- Replaces the fixed 16-lane/6-bit, k0=0, no-filler rate-dematching FSM.

Parameters:
- LANES, 16: LLRs per input-buffer word.
- LLR_W, 6: bits per LLR.
- E_W, 14: width of the E (rate-matched length) count.
- NCB_W, 16: width of Ncb, k0 and filler fields.
- ADDR_W, 16: input-buffer address width.

Ports:
- i_core_clk  in  1  sole clock, rising edge.
- i_rx_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle combine request; sampled only in IDLE.
- i_e_size  in  E_W  number of LLRs to process.
- i_ncb_size  in  NCB_W  circular buffer length.
- i_k0  in  NCB_W  start offset.
- i_filler_start  in  NCB_W  first filler position.
- i_filler_len  in  NCB_W  filler length; 0 means no filler.
- i_base_addr  in  ADDR_W  input-buffer word address of LLR 0.
- o_Input_Buffer_Offset_Address  out  ADDR_W  word read address.
- o_rd_en  out  1  read strobe; data returns exactly 1 cycle later.
- i_Input_Buffer_RDM_Data  in  LANES*LLR_W  read data; lane 0 in MSBs.
- o_llr  out  LLR_W  current LLR.
- o_ncb_addr  out  NCB_W  circular-buffer position of o_llr.
- o_first_pass  out  1  1 until the first wrap; downstream writes when 1, adds when 0.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts beat.
- o_busy  out  1  high from the cycle after start until done.
- o_done  out  1  one-cycle completion pulse.
- o_cfg_err  out  1  sticky config error, cleared on next accepted start.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0.
- Configuration inputs are registered on the accepted i_start and held for the whole job. i_start while busy is ignored.
- States and transitions:
  - IDLE: on i_start → CHECK.
  - CHECK (1 cycle): compute the start position, then → DONE if E==0 or on error, else → FETCH.
  - FETCH: o_rd_en=1, address = base + word_idx → WAIT.
  - WAIT: capture input data into the word register at the end of this cycle → EMIT.
  - EMIT: o_valid=1, o_llr = lane lane_idx. On each valid&&ready: decrement remaining E, advance position, advance lane.
    - remaining hits 0 → DONE.
    - last lane consumed → FETCH with word_idx+1.
    - otherwise stay in EMIT.
  - DONE: o_done=1 for 1 cycle → IDLE.
- Latency: first o_valid is 4 cycles after the cycle i_start is sampled (CHECK, FETCH, WAIT, then EMIT). Throughput is LANES beats per LANES+2 cycles.
- Backpressure: while o_valid && !i_ready, o_llr, o_ncb_addr and o_first_pass hold stable and no counter moves.
- Position advance rule: next = pos+1, with Ncb-1 wrapping to 0; the wrap clears first_pass permanently. If next falls in [filler_start, filler_start+filler_len), jump to filler_start+filler_len, wrapping if that equals Ncb. The filler region never consumes an LLR. All position arithmetic uses NCB_W+1 bits.
- Start position: k0. If k0 lies inside the filler, advance to the filler end as above.
- Config errors: o_cfg_err=1, no reads or beats, o_done still pulses, in any of these cases:
  - Ncb==0.
  - k0>=Ncb.
  - filler_start+filler_len>Ncb.
  - filler_len>=Ncb.
- Partial last word: emission stops at E; unused lanes are discarded and no extra read is issued.
- E>Ncb-filler_len (repetition): positions wrap any number of times; first_pass stays 0 after the first wrap.
- Asynchronous reset mid-job: immediate return to IDLE with all outputs 0. No done pulse.

Decomposition:
- Shared package rdm_pkg holds:
  - State enum: IDLE, CHECK, FETCH, WAIT, EMIT, DONE.
  - Default constants: LANES=16, LLR_W=6, E_W=14, NCB_W=16.
- One natural sub-module, rdm_pos_advance: combinational next-position with wrap and filler skip, returning the wrapped flag. It is used both for the start position in CHECK and for the per-beat advance.

Test Plan:
- E=138, Ncb=98, k0=0, no filler, base=0x100, ready=1 → 138 beats with addresses 0..97 then 0..39. o_first_pass=1 for the first 98 beats. Reads at 0x100..0x108 (9 reads); lane 9 of the last word is the final beat; one o_done.
- Ncb=20, k0=5, filler 8..11, E=10 → o_ncb_addr sequence 5,6,7,12,13,14,15,16,17,18, with first_pass=1 throughout.
- k0=9 inside filler 8..11, Ncb=20, E=12 → starts at 12; sequence 12..19, 0..3; first_pass drops at address 0.
- Same as the first scenario with i_ready toggling at 50% pseudo-random → identical 138-beat sequence, outputs stable during stalls, read count unchanged.
- E=0 → o_done 2 cycles after start, no o_rd_en. Separately, k0=98 with Ncb=98 → o_cfg_err=1, no beats, o_done pulses.
- Assert reset during EMIT at beat 50, release, then restart the first scenario → outputs 0 during reset; the full 138-beat sequence repeats correctly.
